// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Single outstanding request: req/gnt handshake, then exactly one rvalid beat.
`timescale 1ns/1ps
interface fetch_stage_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
) ();
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem fetches
// and drives the IF/ID register, honouring decode stall and branch redirects.
`timescale 1ns/1ps
module fetch_stage #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_stage_if.master          imem,
  input  logic                   StallD,
  input  logic                   PCSrc,
  input  logic [ADDR_WIDTH-1:0]  PCTarget,
  output logic [INSTR_WIDTH-1:0] InstrD,
  output logic [ADDR_WIDTH-1:0]  PCD,
  output logic [ADDR_WIDTH-1:0]  PCPlus4D,
  output logic                   ValidD,
  output logic [5:0]             OpcodeD,
  output logic [4:0]             RdD,
  output logic [2:0]             FuncD
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                 state, stateNext;
  logic [ADDR_WIDTH-1:0]  pc, pcNext, pcInc;
  logic                   discard, discardNext;
  logic                   loadMem, loadBuf, captureBuf, flushD;
  logic [INSTR_WIDTH-1:0] bufInstr;
  logic [ADDR_WIDTH-1:0]  bufPc;

  assign pcInc = pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    discardNext = discard;
    loadMem     = 1'b0;
    loadBuf     = 1'b0;
    captureBuf  = 1'b0;
    flushD      = 1'b0;
    if (PCSrc) begin
      // Redirect wins over stall; a fetch already granted is marked for discard.
      flushD = 1'b1;
      pcNext = PCTarget & ALIGN_MASK;
      case (state)
        S_REQ: begin
          if (imem.imem_gnt) begin
            stateNext   = S_WAIT;
            discardNext = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            stateNext   = S_REQ;
            discardNext = 1'b0;
          end else begin
            discardNext = 1'b1;
          end
        end
        default: stateNext = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem.imem_gnt) stateNext = S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (discard) begin
              discardNext = 1'b0;
              stateNext   = S_REQ;
            end else if (!StallD) begin
              loadMem   = 1'b1;
              pcNext    = pcInc;
              stateNext = S_REQ;
            end else begin
              captureBuf = 1'b1;
              stateNext  = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!StallD) begin
            loadBuf   = 1'b1;
            pcNext    = pcInc;
            stateNext = S_REQ;
          end
        end
        default: stateNext = S_REQ;
      endcase
    end
  end

  always_comb begin
    imem.imem_req  = (state == S_REQ) && !rst;
    imem.imem_addr = pc;
    OpcodeD        = InstrD[31:26];
    RdD            = InstrD[25:21];
    FuncD          = InstrD[2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      discard  <= 1'b0;
      ValidD   <= 1'b0;
      InstrD   <= '0;
      PCD      <= '0;
      PCPlus4D <= '0;
      bufInstr <= '0;
      bufPc    <= '0;
    end else begin
      pc      <= pcNext;
      discard <= discardNext;
      if (captureBuf) begin
        bufInstr <= imem.imem_rdata;
        bufPc    <= pc;
      end
      if (loadMem) begin
        InstrD   <= imem.imem_rdata;
        PCD      <= pc;
        PCPlus4D <= pcInc;
        ValidD   <= 1'b1;
      end else if (loadBuf) begin
        InstrD   <= bufInstr;
        PCD      <= bufPc;
        PCPlus4D <= bufPc + PC_STEP;
        ValidD   <= 1'b1;
      end else if (flushD || !StallD) begin
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a randomized imem responder plus a
// program-order model of the expected IF/ID instruction stream.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam int unsigned AW  = 32;
  localparam int unsigned IW  = 32;
  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallD = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [5:0]  OpcodeD;
  logic [4:0]  RdD;
  logic [2:0]  FuncD;

  fetch_stage_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) imem ();

  fetch_stage #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(RPC)) dut (
    .clk      (clk),
    .rst      (rst),
    .imem     (imem),
    .StallD   (StallD),
    .PCSrc    (PCSrc),
    .PCTarget (PCTarget),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD),
    .OpcodeD  (OpcodeD),
    .RdD      (RdD),
    .FuncD    (FuncD)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h108) return 32'h80A2_0001;
    return (a ^ 32'hA5C3_0F00) * 32'h0001_0DCD + 32'h1234_5677;
  endfunction

  // Expected program-order stream: restarted at reset/redirect, topped up on each pop.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;
  exp_t        sbQ[$];
  logic [31:0] sbNext;

  task automatic sbPush();
    exp_t e;
    e.pc   = sbNext;
    e.word = memWord(sbNext);
    sbQ.push_back(e);
    sbNext += 32'd4;
  endtask

  task automatic sbRestart(input logic [31:0] a);
    sbQ.delete();
    sbNext = a;
    for (int k = 0; k < 4; k++) sbPush();
  endtask

  // Memory responder state
  bit          pendValid = 0;
  int          pendCnt = 0;
  logic [31:0] pendAddr = '0;
  int          gntPct = 100;
  int          latMin = 1;
  int          latMax = 1;
  bit          gntNow, rvalidNow;
  bit          lastStepRst = 1;
  logic [31:0] gntLog[$];
  bit          phase1 = 0;
  int          delivered = 0;

  task automatic step(input bit stall, input bit redir, input logic [31:0] tgt, input bit doRst);
    @(negedge clk);
    #1;
    rst      = doRst;
    StallD   = stall;
    PCSrc    = redir;
    PCTarget = tgt;
    #1;
    gntNow    = 0;
    rvalidNow = 0;
    if (doRst) begin
      pendValid = 0;
      sbRestart(RPC);
      gntLog.delete();
    end else begin
      if (lastStepRst) check("req_after_rst", imem.imem_req, 1);
      if (redir) begin
        sbRestart(tgt & ~32'd3);
        gntLog.delete();
      end
      if (pendValid) begin
        check("single_outstanding", imem.imem_req, 0);
        if (pendCnt == 0) begin
          rvalidNow = 1;
          pendValid = 0;
        end else begin
          pendCnt--;
        end
      end
      if (!pendValid && !rvalidNow && imem.imem_req && int'($urandom_range(99)) < gntPct) begin
        gntNow    = 1;
        pendValid = 1;
        pendCnt   = int'($urandom_range(latMax, latMin)) - 1;
        pendAddr  = imem.imem_addr;
        gntLog.push_back(imem.imem_addr);
      end
    end
    lastStepRst      = doRst;
    imem.imem_gnt    = gntNow;
    imem.imem_rvalid = rvalidNow;
    imem.imem_rdata  = rvalidNow ? memWord(pendAddr) : 32'hDEAD_BEEF;
  endtask

  // Inputs as seen by the most recent active edge
  logic pRst, pStall, pPCSrc, pGnt;
  always @(posedge clk) begin
    pRst   <= rst;
    pStall <= StallD;
    pPCSrc <= PCSrc;
    pGnt   <= imem.imem_gnt;
  end

  initial begin : monitor
    logic        oValid, oReq;
    logic [31:0] oInstr, oPCD, oAddr;
    int          cyc, lastNew, idle;
    exp_t        e;
    cyc = 0; lastNew = -1; idle = 0;
    oValid = 0; oReq = 0; oInstr = '0; oPCD = '0; oAddr = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) check("req_in_rst", imem.imem_req, 0);
      if (!rst && !pRst && oReq && !pGnt && !pPCSrc) begin
        check("req_dropped", imem.imem_req, 1);
        check("addr_stable", imem.imem_addr, oAddr);
      end
      if (pRst) begin
        check("rst_validd", ValidD, 0);
        check("rst_pcd", PCD, 0);
        check("rst_instrd", InstrD, 0);
        lastNew = -1;
        idle = 0;
      end else if (pPCSrc) begin
        check("redirect_flush", ValidD, 0);
      end else if (pStall) begin
        idle = 0;
        if (oValid) begin
          check("hold_valid", ValidD, 1);
          check("hold_instr", InstrD, oInstr);
          check("hold_pcd", PCD, oPCD);
        end else begin
          check("no_load_in_stall", ValidD, 0);
        end
      end else if (ValidD) begin
        idle = 0;
        delivered++;
        check("sb_nonempty", sbQ.size() != 0, 1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          sbPush();
          check("pcd", PCD, e.pc);
          check("instrd", InstrD, e.word);
          check("pcplus4d", PCPlus4D, e.pc + 32'd4);
          check("fields", {OpcodeD, RdD, FuncD}, {e.word[31:26], e.word[25:21], e.word[2:0]});
        end
        if (PCD == 32'h108) begin
          check("opcode_108", OpcodeD, 6'b100000);
          check("rd_108", RdD, 5'b00101);
          check("func_108", FuncD, 3'b001);
        end
        if (phase1 && lastNew >= 0) check("throughput_spacing", cyc - lastNew, 2);
        lastNew = cyc;
      end else begin
        idle++;
        if (idle > 60) begin
          check("progress_idle_cycles", idle, 60);
          idle = 0;
        end
      end
      oValid = ValidD;
      oInstr = InstrD;
      oPCD   = PCD;
      oReq   = imem.imem_req;
      oAddr  = imem.imem_addr;
    end
  end

  task automatic waitGrant(input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      step(0, 0, '0, 0);
      seen = gntNow;
    end
    check(name, seen, 1);
  endtask

  task automatic firstGrantAddr(input string name, input logic [31:0] exp);
    for (int k = 0; k < 30 && gntLog.size() == 0; k++) step(0, 0, '0, 0);
    check({name, "_seen"}, gntLog.size() != 0, 1);
    if (gntLog.size() != 0) check(name, gntLog[0], exp);
  endtask

  initial begin : stimulus
    bit          seen;
    logic [31:0] tgt;
    imem.imem_gnt    = 0;
    imem.imem_rvalid = 0;
    imem.imem_rdata  = '0;

    // Back-to-back fetch from reset, 1-cycle memory
    repeat (3) step(0, 0, '0, 1);
    phase1 = 1;
    repeat (14) step(0, 0, '0, 0);
    phase1 = 0;
    check("gnt_log_len", gntLog.size() >= 3, 1);
    if (gntLog.size() >= 3) begin
      check("addr0", gntLog[0], 32'h100);
      check("addr1", gntLog[1], 32'h104);
      check("addr2", gntLog[2], 32'h108);
    end

    // Redirect while waiting on a response that lands two cycles later
    latMin = 3; latMax = 3;
    waitGrant("wait_grant_a");
    step(0, 1, 32'h203, 0);
    firstGrantAddr("redir_wait_addr", 32'h200);
    repeat (10) step(0, 0, '0, 0);

    // Stall across a response, then release
    latMin = 1; latMax = 1;
    repeat (4) step(0, 0, '0, 0);
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      step(1, 0, '0, 0);
      seen = rvalidNow;
    end
    check("stall_rvalid_seen", seen, 1);
    repeat (3) begin
      step(1, 0, '0, 0);
      check("no_req_in_hold", imem.imem_req, 0);
    end
    step(0, 0, '0, 0);
    @(negedge clk);
    check("release_latency", ValidD, 1);
    repeat (6) step(0, 0, '0, 0);

    // Redirect while holding a buffered word under stall
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      step(1, 0, '0, 0);
      seen = rvalidNow;
    end
    check("hold_rvalid_seen", seen, 1);
    step(1, 1, 32'h300, 0);
    firstGrantAddr("redir_hold_addr", 32'h300);
    repeat (8) step(0, 0, '0, 0);

    // Reset while a response is outstanding
    latMin = 3; latMax = 3;
    waitGrant("wait_grant_b");
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    firstGrantAddr("rst_restart_addr", RPC);
    repeat (8) step(0, 0, '0, 0);

    // Randomized traffic
    gntPct = 70; latMin = 1; latMax = 3;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) begin
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
      end else if ($urandom_range(99) < 4) begin
        tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        step($urandom_range(1) == 1, 1, tgt, 0);
      end else begin
        step($urandom_range(99) < 30, 0, '0, 0);
      end
    end
    repeat (10) step(0, 0, '0, 0);
    check("deliveries_min", delivered > 200, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the scalar/vector pipeline: owns the program counter, issues single-outstanding requests to instruction memory, and drives the IF/ID pipeline register whose instruction slices (Opcode, Rd, Func) feed the control unit in decode. It honours a decode stall and applies branch/jump redirects (PCSrc/PCTarget from the branch-resolve path), squashing any wrong-path fetch in flight.

## Interface
- ADDR_WIDTH, 32, PC and imem address width
- INSTR_WIDTH, 32, instruction word width (must be 32; field slices fixed below)
- RESET_PC, 0, PC value loaded on reset (word aligned)

- clk  in  1  pipeline clock; one clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_WIDTH  fetch address (= PC)
- imem_gnt  in  1  memory accepts request this cycle (req && gnt = handshake)
- imem_rvalid  in  1  response valid; exactly one per granted request, ≥1 cycle after grant
- imem_rdata  in  INSTR_WIDTH  instruction word, valid with imem_rvalid
- StallD  in  1  decode cannot accept; IF/ID holds
- PCSrc  in  1  redirect pulse: take PCTarget
- PCTarget  in  ADDR_WIDTH  redirect address; bits [1:0] ignored (forced 00)
- InstrD  out  INSTR_WIDTH  IF/ID instruction
- PCD  out  ADDR_WIDTH  address of InstrD
- PCPlus4D  out  ADDR_WIDTH  PCD + 4
- ValidD  out  1  IF/ID holds a real instruction; 0 = bubble
- OpcodeD  out  6  InstrD[31:26]
- RdD  out  5  InstrD[25:21]
- FuncD  out  3  InstrD[2:0]

## Operation
- State register: S_REQ (request outstanding-to-be-granted), S_WAIT (granted, awaiting rvalid), S_HOLD (response buffered while StallD). Plus 1-bit discard flag and INSTR_WIDTH+ADDR_WIDTH hold buffer.
- Reset: state=S_REQ, PC=RESET_PC, discard=0, ValidD=0, InstrD/PCD/PCPlus4D=0, imem_req=0 in the reset cycle; imem_req=1 first cycle after rst falls.
- S_REQ: imem_req=1, imem_addr=PC. gnt -> S_WAIT. Address may change only while not granted (redirect).
- S_WAIT: imem_req=0. rvalid && discard -> drop word, discard=0, S_REQ. rvalid && !StallD -> load IF/ID {imem_rdata, PC, PC+4, ValidD=1}, PC<=PC+4, S_REQ. rvalid && StallD -> buffer word+PC, S_HOLD.
- S_HOLD: imem_req=0. !StallD -> load IF/ID from buffer, ValidD=1, PC<=PC+4, S_REQ.
- IF/ID when no load: StallD=1 -> hold all; StallD=0 -> ValidD<=0 (bubble), data fields hold.
- Redirect (PCSrc=1) has priority over everything except rst; StallD ignored that cycle:
  - PC<=PCTarget&~3; ValidD<=0 (flush IF/ID).
  - S_REQ without gnt: stay S_REQ, new address next cycle. S_REQ with gnt: S_WAIT, discard=1.
  - S_WAIT without rvalid: stay, discard=1. S_WAIT with rvalid: drop word, S_REQ.
  - S_HOLD: drop buffer, S_REQ.
- PC arithmetic modulo 2^ADDR_WIDTH; PC+4 from max word address wraps to 0.
- OpcodeD/RdD/FuncD are combinational slices of InstrD; decode must qualify with ValidD.
- Reset mid-fetch: outstanding response arriving after rst is ignored only if it arrives during rst; memory must not respond after reset to pre-reset grants.

## Timing
- Grant in cycle N, rvalid earliest N+1; IF/ID visible cycle N+2.
- Peak throughput: one instruction per 2 cycles (grant, response); next request asserted the cycle after the response.
- Redirect in cycle R: imem_addr=PCTarget no later than R+1 (R+1 if S_REQ/S_HOLD/rvalid in R; after discarded response otherwise); ValidD=0 at R+1.
- StallD release: buffered instruction appears in IF/ID one cycle after StallD falls.

## Test plan
- Reset, RESET_PC=0x100, gnt/rvalid always 1-cycle: imem_addr sequence 0x100,0x104,0x108; InstrD/PCD follow, PCPlus4D=PCD+4, ValidD=1 every other cycle.
- rdata=0x80A2_0001 (Opcode 100000, Rd 00101, Func 001): OpcodeD=6'b100000, RdD=5'b00101, FuncD=3'b001, ValidD=1.
- StallD=1 for 3 cycles while rvalid arrives: IF/ID holds previous instruction, no new req; StallD falls -> buffered word in IF/ID next cycle, single occurrence, no loss/duplication.
- PCSrc with PCTarget=0x203 while S_WAIT, rvalid 2 cycles later: stale word dropped (ValidD stays 0), next imem_addr=0x200.
- PCSrc same cycle as StallD=1 in S_HOLD: buffer dropped, ValidD=0, next req to target.
- rst asserted in S_WAIT: next cycle ValidD=0, imem_req=0, PC=RESET_PC; then fetch restarts at RESET_PC.
